fp_dot_acc: RTL and testbench
=============================

FP_DOT_ACC -- requirements
Module: fp_dot_acc

Interface
REQ-001 Parameter sig_width, default 23, significand width of every FP operand and result.
REQ-002 Parameter exp_width, default 8, exponent width of every FP operand and result.
REQ-003 Parameter ieee_compliance, default 0, passed unchanged to the internal DW_fp_mac_DG instance.
REQ-004 Parameter len_width, default 8, width of the element-count input.
REQ-005 The block SHALL use one clock, clk; reset is rst, synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start  input  1  begin a dot product; sampled only in IDLE.
REQ-009 len  input  len_width  element count, latched on an accepted start.
REQ-010 rnd  input  3  DW rounding mode, latched on an accepted start.
REQ-011 in_valid  input  1  element pair present on in_a/in_b.
REQ-012 in_ready  output  1  block accepts an element this cycle.
REQ-013 in_a, in_b  input  sig_width+exp_width+1 each  FP multiplicand and multiplier.
REQ-014 out_valid  output  1  result present on out_z/out_status.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 out_z  output  sig_width+exp_width+1  final accumulated value.
REQ-017 out_status  output  8  DW status flags of the result.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 The block SHALL drive one DW_fp_mac_DG with a=in_a, b=in_b, c=acc register, rnd=latched rnd, and DG_ctrl = in_valid AND in_ready.
REQ-020 States: IDLE, RUN, DONE; reset state is IDLE.
REQ-021 IDLE, start=1, len!=0: acc <= all-zeros (+0), cnt <= len, sticky <= 0, latch rnd; go to RUN.
REQ-022 IDLE, start=1, len=0: acc <= +0, status register <= 8'h01; go to DONE directly.
REQ-023 RUN: in_ready=1; on every cycle with in_valid=1: acc <= z, sticky[7:1] <= sticky[7:1] OR status[7:1], cnt <= cnt-1.
REQ-024 In RUN, a cycle with in_valid=0 SHALL leave acc, cnt and sticky unchanged; a gap of any length is legal.
REQ-025 Accepting the element with cnt=1 SHALL move to DONE on the next edge; throughput is one element per cycle; latency from the last accept to out_valid is 1 cycle.
REQ-026 On entry to DONE, out_status[7:1] = sticky[7:1] including the final element, and out_status[0] = 1 iff the final acc is +0 or -0.
REQ-027 DONE: out_valid=1, out_z=acc; out_z and out_status SHALL hold stable until out_ready=1; when out_ready=1, go to IDLE on the next edge.
REQ-028 in_ready SHALL be 0 in IDLE and DONE; start SHALL be ignored in RUN and DONE.
REQ-029 Accumulation order is the element arrival order; each step is exactly one fused DW MAC rounding with the latched rnd.
REQ-030 len=2^len_width-1 SHALL complete normally; cnt never wraps below 0.

Reset
REQ-031 While rst=1 at a clock edge, the block SHALL enter IDLE, clear acc, cnt, sticky and status, and drive in_ready=0, out_valid=0, busy=0, out_z=0, out_status=0.
REQ-032 rst SHALL take priority over start, in_valid and out_ready in the same cycle; asserting it mid-RUN or mid-DONE discards the operation, and no out_valid follows.

Verification
REQ-033 len=3, rnd=0, three pairs a=32'h3F800000, b=32'h40000000 back-to-back -> out_valid 1 cycle after the third accept, out_z=32'h40C00000, out_status=8'h00.
REQ-034 start with len=0 -> DONE next cycle, out_z=32'h00000000, out_status=8'h01, no element consumed.
REQ-035 len=1, a=32'h7F7FFFFF, b=32'h40000000, rnd=0 -> out_z=32'h7F800000, out_status=8'h32 (infinity, huge, inexact).
REQ-036 len=4 with in_valid low for 3 cycles between elements, then out_ready held low 5 cycles with start=1 -> result identical to the no-gap run, out_z stable throughout, start ignored, IDLE one cycle after out_ready=1.
REQ-037 rst=1 after 2 of 4 elements -> all outputs reset next cycle, no out_valid; a fresh len=1 run (1.0 x 1.0) then yields out_z=32'h3F800000.
REQ-038 A bench checker SHALL confirm that DG_ctrl is 1 only on accept cycles and 0 in IDLE, DONE and RUN gap cycles.

Source files
------------

// File: rtl/fp_dot_acc.sv
// Streaming floating-point dot-product accumulator built around one fused MAC.
// Elements arrive over a valid/ready handshake; the result is held until consumed.

module DW_fp_mac_DG #(
   parameter int sig_width       = 23,
   parameter int exp_width       = 8,
   parameter int ieee_compliance = 0
) (
   input  logic [sig_width+exp_width:0] a,
   input  logic [sig_width+exp_width:0] b,
   input  logic [sig_width+exp_width:0] c,
   input  logic [2:0]                   rnd,
   input  logic                         DG_ctrl,
   output logic [sig_width+exp_width:0] z,
   output logic [7:0]                   status
);
   localparam int W    = sig_width;
   localparam int E    = exp_width;
   localparam int PW   = 2*W + 2;
   localparam int G    = W + 4;
   localparam int N    = PW + G;
   localparam int SW   = N + 1;
   localparam int KW   = $clog2(SW) + 1;
   localparam int EW   = E + KW + 2;
   localparam int BIAS = (1 << (E-1)) - 1;
   localparam int EMAX = (1 << E) - 1;
   localparam logic [W-1:0] NAN_FRAC =
      (ieee_compliance != 0) ? (W'(1) << (W-1)) : W'(1);

   logic [E-1:0] ea, eb, ecr;
   logic sa, sb, sc, sp;
   logic a_zero, b_zero, c_zero, p_zero;
   logic a_inf, b_inf, c_inf, p_inf, invalid;
   logic [PW-1:0] prod, cx;
   logic signed [EW-1:0] ep, ec, el, d, eres;
   logic [N-1:0] xl, xs, xs_al;
   logic [2*N-1:0] wide;
   logic [KW-1:0] sh, k;
   logic sl, ss, sgn, eff_sub;
   logic [SW-1:0] sum;
   logic [SW-2:0] sn;
   logic [W-1:0] frac, frac_r;
   logic g, st, inc, carry, to_inf;

   assign sa  = a[W+E];
   assign sb  = b[W+E];
   assign sc  = c[W+E];
   assign sp  = sa ^ sb;
   assign ea  = a[W+E-1:W];
   assign eb  = b[W+E-1:W];
   assign ecr = c[W+E-1:W];

   // Subnormals are flushed to zero and NaN encodings behave as infinities.
   assign a_zero  = (ea == '0);
   assign b_zero  = (eb == '0);
   assign c_zero  = (ecr == '0);
   assign a_inf   = &ea;
   assign b_inf   = &eb;
   assign c_inf   = &ecr;
   assign p_zero  = a_zero | b_zero;
   assign p_inf   = a_inf | b_inf;
   assign invalid = (a_inf & b_zero) | (b_inf & a_zero) |
                    (p_inf & c_inf & (sp ^ sc));

   assign prod = PW'({1'b1, a[W-1:0]}) * PW'({1'b1, b[W-1:0]});
   assign cx   = {1'b0, 1'b1, c[W-1:0], {W{1'b0}}};
   assign ep   = EW'(ea) + EW'(eb) - EW'(BIAS);
   assign ec   = EW'(ecr);

   always_comb begin
      xl      = {prod, {G{1'b0}}};
      el      = ep;
      sl      = sp;
      xs      = '0;
      ss      = sc;
      d       = ep - ec;
      sh      = '0;
      sum     = '0;
      sgn     = 1'b0;
      eff_sub = 1'b0;
      if (c_zero || (!p_zero && ep >= ec)) begin
         if (!c_zero) xs = {cx, {G{1'b0}}};
      end else begin
         xl = {cx, {G{1'b0}}};
         el = ec;
         sl = sc;
         ss = sp;
         d  = ec - ep;
         if (!p_zero) xs = {prod, {G{1'b0}}};
      end
      if (d < 0)
         sh = '0;
      else if (d > EW'(N))
         sh = KW'(N);
      else
         sh = KW'(d);
      wide  = {xs, {N{1'b0}}} >> sh;
      xs_al = wide[2*N-1:N] | {{(N-1){1'b0}}, |wide[N-1:0]};
      eff_sub = sl ^ ss;
      if (!eff_sub) begin
         sum = {1'b0, xl} + {1'b0, xs_al};
         sgn = sl;
      end else if (xl >= xs_al) begin
         sum = {1'b0, xl - xs_al};
         sgn = sl;
      end else begin
         sum = {1'b0, xs_al - xl};
         sgn = ss;
      end
   end

   always_comb begin
      k = '0;
      for (int i = 0; i < SW; i++)
         if (sum[i]) k = KW'(i);
      sn   = (SW-1)'(sum << (KW'(SW-1) - k));
      frac = sn[SW-2 -: W];
      g    = sn[SW-2-W];
      st   = |sn[SW-3-W:0];
      case (rnd)
         3'd0:    inc = g & (st | frac[0]);
         3'd1:    inc = 1'b0;
         3'd2:    inc = ~sgn & (g | st);
         3'd3:    inc = sgn & (g | st);
         3'd4:    inc = g;
         3'd5:    inc = g | st;
         default: inc = 1'b0;
      endcase
      {carry, frac_r} = {1'b0, frac} + (W+1)'(inc);
      eres = el + EW'(k) - EW'(2*W + G) + EW'(carry);
      case (rnd)
         3'd1:    to_inf = 1'b0;
         3'd2:    to_inf = ~sgn;
         3'd3:    to_inf = sgn;
         default: to_inf = 1'b1;
      endcase
   end

   always_comb begin
      z      = '0;
      status = '0;
      if (!DG_ctrl) begin
         z      = '0;
         status = '0;
      end else if (invalid) begin
         z         = {1'b0, {E{1'b1}}, NAN_FRAC};
         status[2] = 1'b1;
      end else if (p_inf | c_inf) begin
         z         = {p_inf ? sp : sc, {E{1'b1}}, {W{1'b0}}};
         status[1] = 1'b1;
      end else if (p_zero & c_zero) begin
         z         = {(sp == sc) ? sp : (rnd == 3'd3), {(W+E){1'b0}}};
         status[0] = 1'b1;
      end else if (sum == '0) begin
         z         = {rnd == 3'd3, {(W+E){1'b0}}};
         status[0] = 1'b1;
      end else if (eres >= EW'(EMAX)) begin
         status[4] = 1'b1;
         status[5] = 1'b1;
         status[1] = to_inf;
         if (to_inf)
            z = {sgn, {E{1'b1}}, {W{1'b0}}};
         else
            z = {sgn, E'(EMAX-1), {W{1'b1}}};
      end else if (eres <= 0) begin
         z         = {sgn, {(W+E){1'b0}}};
         status[0] = 1'b1;
         status[3] = 1'b1;
         status[5] = 1'b1;
      end else begin
         z         = {sgn, eres[E-1:0], frac_r};
         status[5] = g | st;
      end
   end
endmodule

module fp_dot_acc #(
   parameter int sig_width       = 23,
   parameter int exp_width       = 8,
   parameter int ieee_compliance = 0,
   parameter int len_width       = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [len_width-1:0]         len,
   input  logic [2:0]                   rnd,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [sig_width+exp_width:0] in_a,
   input  logic [sig_width+exp_width:0] in_b,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [sig_width+exp_width:0] out_z,
   output logic [7:0]                   out_status,
   output logic                         busy
);
   localparam int FW = sig_width + exp_width + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nx;
   logic [FW-1:0] acc, mac_z;
   logic [len_width-1:0] cnt;
   logic [7:1] sticky;
   logic [7:0] status_q, mac_status;
   logic [2:0] rnd_q;
   logic dg_ctrl;

   assign dg_ctrl    = in_valid & in_ready;
   assign out_z      = acc;
   assign out_status = status_q;

   DW_fp_mac_DG #(
      .sig_width(sig_width),
      .exp_width(exp_width),
      .ieee_compliance(ieee_compliance)
   ) u_mac (
      .a(in_a),
      .b(in_b),
      .c(acc),
      .rnd(rnd_q),
      .DG_ctrl(dg_ctrl),
      .z(mac_z),
      .status(mac_status)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start)
               state_nx = (len == '0) ? DONE : RUN;
         end
         RUN: begin
            in_ready = 1'b1;
            if (in_valid && cnt == len_width'(1))
               state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // The final status folds the last element's flags in on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         cnt      <= '0;
         sticky   <= '0;
         status_q <= '0;
         rnd_q    <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            acc      <= '0;
            cnt      <= len;
            sticky   <= '0;
            rnd_q    <= rnd;
            status_q <= (len == '0) ? 8'h01 : 8'h00;
         end
      end else if (state == RUN && dg_ctrl) begin
         acc    <= mac_z;
         sticky <= sticky | mac_status[7:1];
         cnt    <= cnt - len_width'(1);
         if (cnt == len_width'(1))
            status_q <= {sticky | mac_status[7:1], mac_status[0]};
      end
   end
endmodule

// File: tb/tb_fp_dot_acc.sv
// Directed bench for fp_dot_acc: streaming runs, gaps, stalls,
// zero length, overflow, maximum length and mid-run reset.

module tb_fp_dot_acc;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic [2:0]  rnd;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_z;
   logic [7:0]  out_status;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] va [4];
   logic [31:0] vb [4];

   fp_dot_acc dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .len(len),
      .rnd(rnd),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_a(in_a),
      .in_b(in_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_z(out_z),
      .out_status(out_status),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_run(input logic [7:0] l, input logic [2:0] r);
      start = 1'b1;
      len   = l;
      rnd   = r;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input logic [31:0] xa, input logic [31:0] xb);
      in_valid = 1'b1;
      in_a     = xa;
      in_b     = xb;
      #1;
      chk("dg_accept", 32'(dut.dg_ctrl), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ovalid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      va[0] = 32'h3F800000; vb[0] = 32'h40000000;
      va[1] = 32'h3FC00000; vb[1] = 32'h40000000;
      va[2] = 32'h3F000000; vb[2] = 32'h3F000000;
      va[3] = 32'h40400000; vb[3] = 32'hBF800000;

      rst = 1'b1; start = 1'b0; len = '0; rnd = '0;
      in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_iready", 32'(in_ready), 32'd0);
      chk("rst_ovalid", 32'(out_valid), 32'd0);
      chk("rst_z", out_z, 32'd0);
      chk("rst_status", 32'(out_status), 32'd0);
      chk("idle_dg", 32'(dut.dg_ctrl), 32'd0);

      // 3 x (1.0 * 2.0) back to back
      begin_run(8'd3, 3'd0);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_iready", 32'(in_ready), 32'd1);
      feed(32'h3F800000, 32'h40000000);
      feed(32'h3F800000, 32'h40000000);
      chk("a_not_done", 32'(out_valid), 32'd0);
      feed(32'h3F800000, 32'h40000000);
      chk("a_ovalid", 32'(out_valid), 32'd1);
      chk("a_z", out_z, 32'h40C00000);
      chk("a_status", 32'(out_status), 32'h00);
      in_valid = 1'b1;
      #1;
      chk("done_dg", 32'(dut.dg_ctrl), 32'd0);
      chk("done_iready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      drain();

      // zero length goes straight to DONE
      in_valid = 1'b1;
      in_a = 32'h3F800000;
      in_b = 32'h3F800000;
      begin_run(8'd0, 3'd0);
      chk("z_ovalid", 32'(out_valid), 32'd1);
      chk("z_z", out_z, 32'h00000000);
      chk("z_status", 32'(out_status), 32'h01);
      chk("z_dg", 32'(dut.dg_ctrl), 32'd0);
      in_valid = 1'b0;
      drain();

      // overflow to +inf
      begin_run(8'd1, 3'd0);
      feed(32'h7F7FFFFF, 32'h40000000);
      chk("ovf_ovalid", 32'(out_valid), 32'd1);
      chk("ovf_z", out_z, 32'h7F800000);
      chk("ovf_status", 32'(out_status), 32'h32);
      drain();

      // 2 + 3 + 0.25 - 3 = 2.25, no gaps
      begin_run(8'd4, 3'd0);
      for (int i = 0; i < 4; i++) feed(va[i], vb[i]);
      chk("ng_ovalid", 32'(out_valid), 32'd1);
      chk("ng_z", out_z, 32'h40100000);
      chk("ng_status", 32'(out_status), 32'h00);
      drain();

      // same data with 3-cycle gaps and a stalled consumer
      begin_run(8'd4, 3'd0);
      for (int i = 0; i < 4; i++) begin
         feed(va[i], vb[i]);
         if (i < 3) begin
            #1;
            chk("gap_dg", 32'(dut.dg_ctrl), 32'd0);
            tick();
            tick();
            tick();
            chk("gap_busy", 32'(busy), 32'd1);
            chk("gap_ovalid", 32'(out_valid), 32'd0);
         end
      end
      chk("gp_ovalid", 32'(out_valid), 32'd1);
      start = 1'b1;
      len = 8'd2;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_ovalid", 32'(out_valid), 32'd1);
         chk("stall_z", out_z, 32'h40100000);
         chk("stall_status", 32'(out_status), 32'h00);
      end
      start = 1'b0;
      drain();

      // reset in the middle of a run
      begin_run(8'd4, 3'd0);
      feed(va[0], vb[0]);
      feed(va[1], vb[1]);
      rst = 1'b1;
      start = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_ovalid", 32'(out_valid), 32'd0);
      chk("mr_iready", 32'(in_ready), 32'd0);
      chk("mr_z", out_z, 32'd0);
      chk("mr_status", 32'(out_status), 32'd0);
      rst = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mr_quiet", 32'(out_valid), 32'd0);
      end
      begin_run(8'd1, 3'd0);
      feed(32'h3F800000, 32'h3F800000);
      chk("post_ovalid", 32'(out_valid), 32'd1);
      chk("post_z", out_z, 32'h3F800000);
      chk("post_status", 32'(out_status), 32'h00);
      drain();

      // maximum length: 255 x (1.0 * 1.0)
      begin_run(8'd255, 3'd0);
      in_valid = 1'b1;
      in_a = 32'h3F800000;
      in_b = 32'h3F800000;
      for (int i = 0; i < 254; i++) tick();
      chk("max_early", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("max_ovalid", 32'(out_valid), 32'd1);
      chk("max_z", out_z, 32'h437F0000);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
